axi_msg_tx: RTL and testbench

Parametrised AXI4 master that transmits one of NUM_MSG stored byte strings to the UART Lite TX FIFO, one single-beat write per character, on a rising edge of the matching trigger input. It polls the UART status register before each byte so strings longer than the UART FIFO never drop characters. It sits between the board buttons or other event sources and the AXI interconnect. It replaces the fixed single-string, fixed-pacing button sender.

---
 rtl/axi_msg_tx.sv | 210 +++++++++++++++++++++
 tb/tb_axi_msg_tx.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_msg_tx.sv
// AXI4 master that sends one of NUM_MSG stored strings to a UART Lite TX FIFO,
// one single-beat write per byte, optionally polling the status register first.
module axi_msg_tx #(
  parameter logic [31:0]                                 BASE_ADDR = 32'h4060_0000,
  parameter int                                          MSG_DEPTH = 16,
  parameter int                                          NUM_MSG   = 4,
  parameter logic [NUM_MSG*MSG_DEPTH*8-1:0]              MSG_ROM   = '0,
  parameter logic [NUM_MSG*$clog2(MSG_DEPTH+1)-1:0]      MSG_LEN   = '0,
  parameter bit                                          POLL      = 1'b1
) (
  input  logic               M_AXI_ACLK,
  input  logic               M_AXI_ARESETN,
  output logic [31:0]        M_AXI_AWADDR,
  output logic [7:0]         M_AXI_AWLEN,
  output logic [2:0]         M_AXI_AWSIZE,
  output logic [1:0]         M_AXI_AWBURST,
  output logic [2:0]         M_AXI_AWPROT,
  output logic               M_AXI_AWVALID,
  input  logic               M_AXI_AWREADY,
  output logic [63:0]        M_AXI_WDATA,
  output logic [7:0]         M_AXI_WSTRB,
  output logic               M_AXI_WLAST,
  output logic               M_AXI_WVALID,
  input  logic               M_AXI_WREADY,
  input  logic               M_AXI_BVALID,
  input  logic [1:0]         M_AXI_BRESP,
  output logic               M_AXI_BREADY,
  output logic [31:0]        M_AXI_ARADDR,
  output logic [7:0]         M_AXI_ARLEN,
  output logic [2:0]         M_AXI_ARSIZE,
  output logic [1:0]         M_AXI_ARBURST,
  output logic [2:0]         M_AXI_ARPROT,
  output logic               M_AXI_ARVALID,
  input  logic               M_AXI_ARREADY,
  input  logic [63:0]        M_AXI_RDATA,
  input  logic [1:0]         M_AXI_RRESP,
  input  logic               M_AXI_RLAST,
  input  logic               M_AXI_RVALID,
  output logic               M_AXI_RREADY,
  input  logic [NUM_MSG-1:0] trig,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int LW = $clog2(MSG_DEPTH + 1);
  localparam int MW = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;

  typedef enum logic [2:0] {IDLE, POLL_AR, POLL_R, WR, WR_B, NEXT} state_t;

  state_t             state;
  logic [NUM_MSG-1:0] sync1, sync2, sync3, pending, take;
  logic [MW-1:0]      sel, cur, rom_msg;
  logic [LW-1:0]      idx, rom_idx, sel_len, cur_len;
  logic [7:0]         cur_byte;
  logic               last_byte;

  assign M_AXI_AWLEN   = 8'd0;
  assign M_AXI_AWSIZE  = 3'b010;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWPROT  = 3'd0;
  assign M_AXI_ARLEN   = 8'd0;
  assign M_AXI_ARSIZE  = 3'b010;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARPROT  = 3'd0;

  // Only the TX-full bit of the status word matters.
  logic unused_rd;
  assign unused_rd = &{1'b0, M_AXI_RDATA[63:4], M_AXI_RDATA[2:0], M_AXI_RLAST};

  // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
  always_comb begin
    sel = '0;
    for (int i = NUM_MSG - 1; i >= 0; i--)
      if (pending[i]) sel = MW'(i);
  end

  // In IDLE the byte mux looks ahead at the message about to be selected.
  assign rom_msg  = (state == IDLE) ? sel : cur;
  assign rom_idx  = (state == IDLE) ? '0 : idx;
  assign cur_byte = MSG_ROM[(int'(rom_msg) * MSG_DEPTH + int'(rom_idx)) * 8 +: 8];
  assign sel_len  = MSG_LEN[int'(sel) * LW +: LW];
  assign cur_len  = MSG_LEN[int'(cur) * LW +: LW];
  assign take     = (state == IDLE && |pending) ? (NUM_MSG'(1) << sel) : '0;

  // New edges are OR-ed in after the clear so a same-cycle edge is never lost.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      sync1   <= '0;
      sync2   <= '0;
      sync3   <= '0;
      pending <= '0;
    end else begin
      // NOTE: non-blocking assignments let each stage capture the previous stage's old value.
      sync1   <= trig;
      sync2   <= sync1;
      sync3   <= sync2;
      pending <= (pending & ~take) | (sync2 & ~sync3);
    end
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state         <= IDLE;
      cur           <= '0;
      idx           <= '0;
      last_byte     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_WLAST   <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      done <= 1'b0;
      if ((M_AXI_BVALID && M_AXI_BREADY && M_AXI_BRESP != 2'b00) ||
          (M_AXI_RVALID && M_AXI_RREADY && M_AXI_RRESP != 2'b00))
        err <= 1'b1;

      case (state)
        IDLE: begin
          if (|pending) begin
            cur <= sel;
            idx <= '0;
            if (sel_len != '0) begin
              busy <= 1'b1;
              if (POLL) begin
                state         <= POLL_AR;
                M_AXI_ARVALID <= 1'b1;
                M_AXI_ARADDR  <= BASE_ADDR + 32'd8;
              end else begin
                state         <= WR;
                M_AXI_AWVALID <= 1'b1;
                M_AXI_WVALID  <= 1'b1;
                M_AXI_AWADDR  <= BASE_ADDR + 32'd4;
                M_AXI_WDATA   <= {24'h0, cur_byte, 32'h0};
                M_AXI_WSTRB   <= 8'hF0;
                M_AXI_WLAST   <= 1'b1;
              end
            end
          end
        end
        POLL_AR: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= POLL_R;
          end
        end
        POLL_R: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            if (M_AXI_RDATA[3]) begin
              state         <= POLL_AR;
              M_AXI_ARVALID <= 1'b1;
            end else begin
              state         <= WR;
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              M_AXI_AWADDR  <= BASE_ADDR + 32'd4;
              M_AXI_WDATA   <= {24'h0, cur_byte, 32'h0};
              M_AXI_WSTRB   <= 8'hF0;
              M_AXI_WLAST   <= 1'b1;
            end
          end
        end
        WR: begin
          if (M_AXI_AWREADY) M_AXI_AWVALID <= 1'b0;
          if (M_AXI_WREADY)  M_AXI_WVALID  <= 1'b0;
          if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY)) begin
            state        <= WR_B;
            M_AXI_BREADY <= 1'b1;
          end
        end
        WR_B: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            last_byte    <= (idx + LW'(1) == cur_len);
            if (idx + LW'(1) != cur_len) idx <= idx + LW'(1);
            state        <= NEXT;
          end
        end
        NEXT: begin
          if (last_byte) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (POLL) begin
            state         <= POLL_AR;
            M_AXI_ARVALID <= 1'b1;
          end else begin
            state         <= WR;
            M_AXI_AWVALID <= 1'b1;
            M_AXI_WVALID  <= 1'b1;
            M_AXI_WDATA   <= {24'h0, cur_byte, 32'h0};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_msg_tx.sv
// Self-checking bench for axi_msg_tx: a small AXI slave with programmable
// backpressure, status-full and error injection, plus a byte scoreboard.
module tb_axi_msg_tx;

  localparam logic [31:0] BASE  = 32'h4060_0000;
  localparam int          DEPTH = 16;
  localparam int          NMSG  = 4;
  localparam int          LW    = 5;

  function automatic int msg_len(input int m);
    case (m)
      0:       return 4;
      1:       return 2;
      2:       return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [7:0] msg_byte(input int m, input int i);
    logic [31:0] s;
    case (m)
      0:       s = 32'h68690D0A;
      1:       s = 32'h41420000;
      2:       s = 32'h78797A00;
      default: s = 32'h0;
    endcase
    return s[(3 - i) * 8 +: 8];
  endfunction

  function automatic logic [NMSG*DEPTH*8-1:0] mk_rom();
    logic [NMSG*DEPTH*8-1:0] r;
    r = '0;
    for (int m = 0; m < NMSG; m++)
      for (int i = 0; i < msg_len(m); i++)
        r[(m * DEPTH + i) * 8 +: 8] = msg_byte(m, i);
    return r;
  endfunction

  function automatic logic [NMSG*LW-1:0] mk_len();
    logic [NMSG*LW-1:0] r;
    r = '0;
    for (int m = 0; m < NMSG; m++) r[m * LW +: LW] = LW'(msg_len(m));
    return r;
  endfunction

  localparam logic [NMSG*DEPTH*8-1:0] ROM = mk_rom();
  localparam logic [NMSG*LW-1:0]      LEN = mk_len();

  logic        clk, rst_n;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, awprot, arsize, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [63:0] wdata, rdata;
  logic [NMSG-1:0] trig;
  logic        busy, done, err;

  axi_msg_tx #(
    .BASE_ADDR(BASE), .MSG_DEPTH(DEPTH), .NUM_MSG(NMSG),
    .MSG_ROM(ROM), .MSG_LEN(LEN), .POLL(1'b1)
  ) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWBURST(awburst), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BVALID(bvalid), .M_AXI_BRESP(bresp), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(1'b1),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .trig(trig), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- slave model ----------------
  int aw_dly = 0, w_dly = 0, aw_wait = 0, w_wait = 0;
  int full_until = 0, err_at = -1, s_rd = 0, s_b = 0;
  logic aw_got, w_got;

  assign awready = (aw_wait >= aw_dly);
  assign wready  = (w_wait >= w_dly);
  assign arready = 1'b1;
  assign rresp   = 2'b00;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_wait <= 0;
      w_wait  <= 0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      bvalid  <= 1'b0;
      bresp   <= 2'b00;
      aw_got  <= 1'b0;
      w_got   <= 1'b0;
    end else begin
      if (awvalid && awready) aw_wait <= 0;
      else if (awvalid)       aw_wait <= aw_wait + 1;
      if (wvalid && wready)   w_wait <= 0;
      else if (wvalid)        w_wait <= w_wait + 1;

      if (rvalid && rready) rvalid <= 1'b0;
      else if (arvalid && arready) begin
        rvalid <= 1'b1;
        rdata  <= (s_rd < full_until) ? 64'h8 : 64'h0;
        s_rd   <= s_rd + 1;
      end

      if (bvalid && bready) bvalid <= 1'b0;
      else if (!bvalid && (aw_got || (awvalid && awready)) && (w_got || (wvalid && wready))) begin
        bvalid <= 1'b1;
        bresp  <= (s_b == err_at) ? 2'b10 : 2'b00;
        s_b    <= s_b + 1;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else begin
        if (awvalid && awready) aw_got <= 1'b1;
        if (wvalid && wready)   w_got  <= 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [7:0] exp_q[$];
  int rd_at_wr[$];
  int busy_cnt = 0, done_cnt = 0, rd_cnt = 0, aw_cnt = 0, wr_cnt = 0, b_cnt = 0;
  logic last_full = 1'b0;
  logic ar_hold = 1'b0, aw_hold = 1'b0, w_hold = 1'b0;
  logic [31:0] ar_prev, aw_prev;
  logic [72:0] w_prev;

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (ar_hold) check("ar_stable", {arvalid, araddr}, {1'b1, ar_prev});
      if (aw_hold) check("aw_stable", {awvalid, awaddr}, {1'b1, aw_prev});
      if (w_hold)  check("w_stable", {wvalid, wdata, wstrb, wlast}, {1'b1, w_prev});
      ar_hold = arvalid && !arready;
      aw_hold = awvalid && !awready;
      w_hold  = wvalid && !wready;
      ar_prev = araddr;
      aw_prev = awaddr;
      w_prev  = {wdata, wstrb, wlast};

      if (arvalid && arready) begin
        rd_cnt++;
        check("araddr", araddr, BASE + 32'd8);
      end
      if (rvalid && rready) last_full = rdata[3];
      if (awvalid && awready) begin
        aw_cnt++;
        check("awaddr", awaddr, BASE + 32'd4);
      end
      if (wvalid && wready) begin
        rd_at_wr.push_back(rd_cnt);
        wr_cnt++;
        check("wr_while_full", last_full, 1'b0);
        check("wr_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) check("wdata", wdata, {24'h0, exp_q.pop_front(), 32'h0});
        check("wstrb_wlast", {wstrb, wlast}, {8'hF0, 1'b1});
      end
      if (bvalid && bready) b_cnt++;
    end else begin
      ar_hold   = 1'b0;
      aw_hold   = 1'b0;
      w_hold    = 1'b0;
      last_full = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push_msg(input int m);
    for (int i = 0; i < msg_len(m); i++) exp_q.push_back(msg_byte(m, i));
  endtask

  task automatic pulse(input logic [NMSG-1:0] mask);
    tick();
    trig = mask;
    repeat (3) tick();
    trig = '0;
  endtask

  task automatic wait_idle(input int target, input int budget);
    bool_loop: for (int c = 0; c < budget; c++) begin
      tick();
      if (done_cnt >= target && !busy) return;
    end
    check("timeout_done", done_cnt, target);
  endtask

  // Sends one message and checks its write/response/done accounting.
  task automatic send(input int m);
    int d0, w0, b0;
    d0 = done_cnt; w0 = wr_cnt; b0 = b_cnt;
    push_msg(m);
    pulse(NMSG'(1) << m);
    wait_idle(d0 + 1, 400);
    repeat (4) tick();
    check("done_cnt", done_cnt - d0, 1);
    check("wr_cnt", wr_cnt - w0, msg_len(m));
    check("b_cnt", b_cnt - b0, msg_len(m));
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, bz0, r0, w0, a0, ar0, c;
    rst_n = 1'b0;
    trig  = '0;
    repeat (3) tick();
    check("rst_valids", {arvalid, awvalid, wvalid, bready, rready}, 5'b0);
    check("rst_status", {busy, done, err}, 3'b0);
    check("rst_awaddr", awaddr, 32'h0);
    check("rst_araddr", araddr, 32'h0);
    check("rst_wdata", wdata, 64'h0);
    check("fixed_fields", {awlen, awsize, awburst, awprot, arlen, arsize, arburst, arprot},
          {8'd0, 3'b010, 2'b01, 3'd0, 8'd0, 3'b010, 2'b01, 3'd0});
    rst_n = 1'b1;
    repeat (2) tick();

    // basic message with zero-wait slave
    d0 = done_cnt; bz0 = busy_cnt;
    send(0);
    check("busy_cycles", busy_cnt - bz0, 20);

    // backpressure on each write channel
    aw_dly = 3;
    send(0);
    aw_dly = 0; w_dly = 3;
    send(0);
    w_dly = 0;

    // status full for the first five polls
    full_until = s_rd + 5;
    r0 = rd_cnt; w0 = wr_cnt;
    send(0);
    check("reads_before_wr", rd_at_wr[w0] - r0, 6);
    check("reads_total", rd_cnt - r0, 9);

    // priority and queueing while message 0 is active
    d0 = done_cnt; w0 = wr_cnt;
    push_msg(0);
    pulse(4'b0001);
    for (c = 0; c < 50 && !busy; c++) tick();
    check("busy_started", busy, 1'b1);
    push_msg(1);
    push_msg(2);
    pulse(4'b0110);
    wait_idle(d0 + 3, 600);
    repeat (4) tick();
    check("prio_done", done_cnt - d0, 3);
    check("prio_writes", wr_cnt - w0, 9);
    check("prio_queue", exp_q.size(), 0);

    // error response on byte 2, message continues
    check("err_clear", err, 1'b0);
    err_at = s_b + 2;
    send(0);
    check("err_sticky", err, 1'b1);
    err_at = -1;

    // zero-length message: no traffic, no done
    d0 = done_cnt; bz0 = busy_cnt; a0 = aw_cnt; ar0 = rd_cnt;
    pulse(4'b1000);
    repeat (20) tick();
    check("zl_done", done_cnt - d0, 0);
    check("zl_busy", busy_cnt - bz0, 0);
    check("zl_traffic", (aw_cnt - a0) + (rd_cnt - ar0), 0);

    // async reset while waiting for a B response
    push_msg(0);
    pulse(4'b0001);
    for (c = 0; c < 100 && !bready; c++) tick();
    check("reached_wr_b", bready, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valids", {arvalid, awvalid, wvalid, bready, rready}, 5'b0);
    check("rst_mid_status", {busy, done, err}, 3'b0);
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("post_rst_busy", busy, 1'b0);
    send(0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
